// File: rtl/l1_dcache.sv
// Direct-mapped, write-back, write-allocate L1 data cache: 8 sets x 16-byte lines,
// 16-bit byte addresses, 128-bit line fills and writebacks to physical memory.
//
//   state       | meaning
//   ------------+-------------------------------------------------------------
//   S_IDLE      | lookup; hits complete in the request cycle
//   S_WRITEBACK | dirty victim line going out to pmem, held until pmem_resp
//   S_ALLOCATE  | missed line being fetched from pmem, held until pmem_resp
module l1_dcache (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_wdata,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t       state;
    logic [7:0]   valid;
    logic [7:0]   dirty;
    logic [8:0]   tag_arr  [8];
    logic [127:0] data_arr [8];

    // Line address of the outstanding miss, so a pmem transaction finishes
    // against the right set even if the CPU drops or changes its request.
    logic [11:0]  miss_line;
    logic [2:0]   miss_idx;

    logic [2:0]   index;
    logic [8:0]   addr_tag;
    logic [2:0]   word_sel;
    logic         req;
    logic         is_write;
    logic         hit;
    logic         unused_ok;

    assign index     = mem_address[6:4];
    assign addr_tag  = mem_address[15:7];
    assign word_sel  = mem_address[3:1];
    assign unused_ok = mem_address[0];
    assign miss_idx  = miss_line[2:0];

    assign req      = mem_read | mem_write;
    assign is_write = mem_write & ~mem_read;
    assign hit      = valid[index] && (tag_arr[index] == addr_tag);

    assign mem_rdata = data_arr[index][{word_sel, 4'b0000} +: 16];
    assign mem_resp  = !reset && (state == S_IDLE) && req && hit;

    assign pmem_read    = !reset && (state == S_ALLOCATE);
    assign pmem_write   = !reset && (state == S_WRITEBACK);
    assign pmem_wdata   = data_arr[miss_idx];
    assign pmem_address = (state == S_WRITEBACK) ? {tag_arr[miss_idx], miss_idx, 4'b0000}
                                                 : {miss_line, 4'b0000};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            valid <= '0;
            dirty <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        if (hit) begin
                            if (is_write)
                                dirty[index] <= 1'b1;
                        end else begin
                            miss_line <= mem_address[15:4];
                            state     <= dirty[index] ? S_WRITEBACK : S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (pmem_resp)
                        state <= S_ALLOCATE;
                end
                S_ALLOCATE: begin
                    if (pmem_resp) begin
                        valid[miss_idx] <= 1'b1;
                        dirty[miss_idx] <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Tag and data storage carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_IDLE && req && hit && is_write) begin
                if (mem_byte_enable[0])
                    data_arr[index][{word_sel, 4'b0000} +: 8] <= mem_wdata[7:0];
                if (mem_byte_enable[1])
                    data_arr[index][{word_sel, 4'b1000} +: 8] <= mem_wdata[15:8];
            end else if (state == S_ALLOCATE && pmem_resp) begin
                data_arr[miss_idx] <= pmem_rdata;
                tag_arr[miss_idx]  <= miss_line[11:3];
            end
        end
    end

endmodule

// File: tb/tb_l1_dcache.sv
// Self-checking bench for l1_dcache: directed scenarios followed by random traffic,
// checked against a set-level cache model and a flat physical-memory model.
module tb_l1_dcache;

    logic         clk;
    logic         reset;
    logic [15:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_wdata;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    l1_dcache dut (
        .clk             (clk),
        .reset           (reset),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .pmem_address    (pmem_address),
        .pmem_read       (pmem_read),
        .pmem_write      (pmem_write),
        .pmem_wdata      (pmem_wdata),
        .pmem_rdata      (pmem_rdata),
        .pmem_resp       (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Physical memory as the responder holds it, and as it should hold it.
    logic [127:0] bmem      [4096];
    logic [127:0] model_mem [4096];

    // Cache model: what each set should hold.
    logic         m_valid [8];
    logic         m_dirty [8];
    logic [8:0]   m_tag   [8];
    logic [127:0] m_data  [8];

    logic [15:0]  rd_obs;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_resp"}, 128'(mem_resp), 128'(0));
        chk({tag, "_pr"}, 128'(pmem_read), 128'(0));
        chk({tag, "_pw"}, 128'(pmem_write), 128'(0));
    endtask

    task automatic model_reset();
        for (int s = 0; s < 8; s++) begin
            m_valid[s] = 1'b0;
            m_dirty[s] = 1'b0;
        end
    endtask

    // One complete CPU request; the model decides hit/miss/writeback and timing.
    task automatic access(input logic [15:0] addr, input bit rd, input bit wr,
                          input logic [1:0] be, input logic [15:0] wd, input int lat,
                          output logic [15:0] rdata_obs);
        logic [2:0]  idx;
        logic [8:0]  tg;
        logic [2:0]  w;
        logic [11:0] line;
        logic [11:0] vline;
        idx  = addr[6:4];
        tg   = addr[15:7];
        w    = addr[3:1];
        line = addr[15:4];
        mem_address     = addr;
        mem_read        = rd;
        mem_write       = wr;
        mem_byte_enable = be;
        mem_wdata       = wd;
        if (!(m_valid[idx] && m_tag[idx] == tg)) begin
            @(negedge clk);
            check_quiet("miss_idle");
            step();
            if (m_dirty[idx]) begin
                vline = {m_tag[idx], idx};
                for (int c = 0; c < lat; c++) begin
                    @(negedge clk);
                    chk("wb_pw", 128'(pmem_write), 128'(1));
                    chk("wb_pr", 128'(pmem_read), 128'(0));
                    chk("wb_resp", 128'(mem_resp), 128'(0));
                    chk("wb_addr", 128'(pmem_address), 128'({vline, 4'b0000}));
                    chk("wb_data", pmem_wdata, m_data[idx]);
                    pmem_resp = (c == lat - 1);
                    if (c == lat - 1)
                        bmem[vline] = pmem_wdata;
                    step();
                    pmem_resp = 1'b0;
                end
                model_mem[vline] = m_data[idx];
                m_dirty[idx] = 1'b0;
            end
            for (int c = 0; c < lat; c++) begin
                @(negedge clk);
                pmem_rdata = bmem[line];
                chk("al_pr", 128'(pmem_read), 128'(1));
                chk("al_pw", 128'(pmem_write), 128'(0));
                chk("al_resp", 128'(mem_resp), 128'(0));
                chk("al_addr", 128'(pmem_address), 128'({line, 4'b0000}));
                pmem_resp = (c == lat - 1);
                step();
                pmem_resp  = 1'b0;
                pmem_rdata = {4{$urandom}};
            end
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
            m_dirty[idx] = 1'b0;
            m_data[idx]  = model_mem[line];
        end
        @(negedge clk);
        chk("hit_resp", 128'(mem_resp), 128'(1));
        chk("hit_pr", 128'(pmem_read), 128'(0));
        chk("hit_pw", 128'(pmem_write), 128'(0));
        rdata_obs = mem_rdata;
        if (rd) begin
            chk("hit_rdata", 128'(mem_rdata), 128'(m_data[idx][{w, 4'b0000} +: 16]));
        end else begin
            if (be[0]) m_data[idx][{w, 4'b0000} +: 8] = wd[7:0];
            if (be[1]) m_data[idx][{w, 4'b1000} +: 8] = wd[15:8];
            m_dirty[idx] = 1'b1;
        end
        step();
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Start a clean read miss and hit it with a one-cycle reset mid-fill.
    task automatic reset_mid_fill(input logic [15:0] addr);
        mem_address = addr;
        mem_read    = 1'b1;
        mem_write   = 1'b0;
        @(negedge clk);
        check_quiet("rst_idle");
        step();
        @(negedge clk);
        chk("rst_fill_pr", 128'(pmem_read), 128'(1));
        step();
        reset = 1'b1;
        @(negedge clk);
        check_quiet("rst_during");
        step();
        reset    = 1'b0;
        mem_read = 1'b0;
        model_reset();
    endtask

    initial begin
        reset           = 1'b1;
        mem_address     = '0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        pmem_rdata      = '0;
        pmem_resp       = 1'b0;
        for (int k = 0; k < 4096; k++) begin
            for (int i = 0; i < 8; i++)
                bmem[k][16*i +: 16] = 16'(16'h1111 * (i + 1) + (k - 1) * 16'h0101);
            model_mem[k] = bmem[k];
        end
        model_reset();

        step();
        @(negedge clk);
        check_quiet("in_reset");
        step();
        reset = 1'b0;
        @(negedge clk);
        check_quiet("after_reset");
        step();

        access(16'h0010, 1, 0, 2'b00, 16'h0000, 3, rd_obs);
        chk("plan_fill_0010", 128'(rd_obs), 128'(16'h1111));
        access(16'h001E, 1, 0, 2'b00, 16'h0000, 3, rd_obs);
        chk("plan_hit_001e", 128'(rd_obs), 128'(16'h8888));
        access(16'h0012, 0, 1, 2'b01, 16'hABCD, 3, rd_obs);
        access(16'h0012, 1, 0, 2'b00, 16'h0000, 3, rd_obs);
        chk("plan_merge_0012", 128'(rd_obs), 128'(16'h22CD));
        access(16'h0090, 1, 0, 2'b00, 16'h0000, 2, rd_obs);
        access(16'h0010, 1, 0, 2'b00, 16'h0000, 2, rd_obs);
        chk("plan_refill_0012", 128'(bmem[1][31:16]), 128'(16'h22CD));
        access(16'h0110, 1, 0, 2'b00, 16'h0000, 2, rd_obs);
        access(16'h0010, 1, 0, 2'b00, 16'h0000, 1, rd_obs);
        reset_mid_fill(16'h0310);
        access(16'h0010, 1, 0, 2'b00, 16'h0000, 2, rd_obs);
        access(16'h0010, 1, 1, 2'b11, 16'hFFFF, 1, rd_obs);
        chk("plan_rw_both", 128'(rd_obs), 128'(16'h1111));
        access(16'h0090, 1, 0, 2'b00, 16'h0000, 2, rd_obs);

        for (int n = 0; n < 250; n++) begin
            logic [15:0] a;
            int          op;
            a  = {7'($urandom_range(0, 3)), 3'($urandom), 4'($urandom), 2'b00};
            a  = {a[15:7], a[6:0] >> 2};
            op = $urandom_range(0, 3);
            access(a, op != 2, op >= 2, 2'($urandom), 16'($urandom),
                   $urandom_range(1, 4), rd_obs);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                pmem_resp = 1'($urandom);
                @(negedge clk);
                check_quiet("gap");
                step();
                pmem_resp = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l1_dcache.md
# l1_dcache

Direct-mapped, write-back, write-allocate L1 data cache that sits directly downstream of the CPU datapath's memory stage. It consumes the datapath's `d_mem_*` request signals and produces `d_mem_rdata`/`d_mem_resp`. Misses are serviced over a 128-bit line interface to physical memory. The geometry is 8 sets of 16-byte lines (8 words each), with 16-bit byte addresses.

## Interface
- Parameters: none. Geometry is fixed: offset = address[3:0], index = address[6:4], tag = address[15:7] (9 bits).
- `clk`  in  1  sole clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `mem_address`  in  16  CPU byte address; bits [3:1] select the word in the line, bit 0 is ignored
- `mem_read`  in  1  CPU read request; held until `mem_resp`
- `mem_write`  in  1  CPU write request; held until `mem_resp`
- `mem_byte_enable`  in  2  write byte lanes; bit 0 = [7:0], bit 1 = [15:8]
- `mem_wdata`  in  16  write data
- `mem_rdata`  out  16  word at `mem_address` from the cached line
- `mem_resp`  out  1  request complete; 1-cycle pulse per request
- `pmem_address`  out  16  line address; bits [3:0] are always 0
- `pmem_read`  out  1  line fill request; held until `pmem_resp`
- `pmem_write`  out  1  line writeback request; held until `pmem_resp`
- `pmem_wdata`  out  128  victim line; word i occupies bits [16i+15:16i]
- `pmem_rdata`  in  128  fill line, same word packing as `pmem_wdata`
- `pmem_resp`  in  1  physical memory transaction done; sampled on the rising edge

## Operation
- Storage per set: valid bit, dirty bit, 9-bit tag, 128-bit data. `reset` clears valid and dirty in all sets. Tag and data arrays are not reset.
- FSM states:
  - IDLE (lookup)
  - WRITEBACK
  - ALLOCATE
- Hit condition: valid[index] and tag[index] == address[15:7], while in IDLE with `mem_read` or `mem_write` asserted.
- IDLE, read hit: `mem_resp`=1 combinationally in the same cycle. `mem_rdata` = data word [3:1].
- IDLE, write hit: `mem_resp`=1 in the same cycle. At the edge, the enabled bytes of the word are updated and dirty[index] is set.
- IDLE, miss with dirty[index]=0: go to ALLOCATE.
- IDLE, miss with dirty[index]=1: go to WRITEBACK.
- WRITEBACK:
  - `pmem_write`=1, `pmem_address`={stored tag, index, 4'b0}, `pmem_wdata`=stored line.
  - On `pmem_resp`, go to ALLOCATE.
- ALLOCATE:
  - `pmem_read`=1, `pmem_address`={address[15:4], 4'b0}.
  - On `pmem_resp`, load `pmem_rdata` into the set, load the tag, set valid, clear dirty, and return to IDLE.
  - The request then hits in IDLE.
- `mem_read` and `mem_write` both high: treated as a read. No array write occurs.
- `mem_rdata` is always driven from the indexed set, including on misses. It is only meaningful when `mem_resp`=1.
- Once started, a pmem transaction is never aborted by the CPU dropping its request; it runs to `pmem_resp`. It is aborted only by `reset`.
- No request in IDLE: no state change, all handshake outputs 0.

## Timing
- Reset values: state IDLE; `mem_resp`, `pmem_read`, `pmem_write` = 0.
  - These three outputs are forced to 0 during any cycle in which `reset` is high, including mid-WRITEBACK or mid-ALLOCATE.
  - The next cycle starts in IDLE with all lines invalid.
- Hit latency: 0 cycles (`mem_resp` in the request cycle).
- Clean miss: 1 IDLE cycle, then ALLOCATE for L cycles (L = pmem latency, `pmem_resp` in the last), then 1 IDLE hit cycle with `mem_resp`. Total L+2 cycles.
- Dirty miss: Lw+Lr+2 cycles.
- `pmem_read`/`pmem_write` are registered-state decodes. They are stable for the whole transaction and never both high.
- A `pmem_resp` arriving while in IDLE is ignored.
- Back-to-back hits: one `mem_resp` per cycle. The CPU changing address in the cycle after `mem_resp` is legal.

## Test plan
- Reset, then read 0x0010. pmem returns word i = 0x1111*(i+1) after 3 cycles.
  - Required: `pmem_read`=1 with `pmem_address`=0x0010 for 3 cycles.
  - Required: `mem_resp`=1 with `mem_rdata`=0x1111 on the following cycle.
  - Then read 0x001E: hits in the same cycle with `mem_rdata`=0x8888 and no pmem activity.
- Write 0x0012 with `mem_byte_enable`=2'b01, `mem_wdata`=0xABCD.
  - Required: `mem_resp` in the same cycle.
  - Required: a following read of 0x0012 returns 0x22CD.
- Read 0x0090 (same index 1, tag 1).
  - Required: `pmem_write` with `pmem_address`=0x0010 and `pmem_wdata`[31:16]=0x22CD.
  - Required: then `pmem_read` with `pmem_address`=0x0090.
  - Required: a subsequent read of 0x0010 misses again.
- Read 0x0110 (index 1) when the resident line is clean: `pmem_write` is never asserted; the miss goes straight to `pmem_read` 0x0110.
- Assert `reset` for 1 cycle while `pmem_read` is high.
  - Required: `pmem_read`=0 in that cycle.
  - Required: the next read of 0x0010 misses, even if it was previously cached.
- Hold `mem_read`=`mem_write`=1 on a hit with `mem_wdata`=0xFFFF: `mem_resp`=1, the line is unchanged, and dirty stays 0 (a later eviction of that set produces no `pmem_write`).
